// File: rtl/sw_led_ctrl.sv
// sw_led_ctrl: synchronised, debounced switches drive the LEDs in DIRECT, TOGGLE, CHASE or BLINK mode.
// Defining SW_LED_PWM_EN adds the bright input and a free-running PWM brightness stage.
module sw_led_ctrl #(
   parameter int WIDTH      = 16,
   parameter int DEB_CYCLES = 100000,
   parameter int TICK_DIV   = 25000000,
   parameter int PWM_BITS   = 4
) (
   input  logic                CLK100MHZ,
   input  logic                CPU_RESETN,
   input  logic [WIDTH-1:0]    sw,
   input  logic [1:0]          mode,
`ifdef SW_LED_PWM_EN
   input  logic [PWM_BITS-1:0] bright,
`endif
   output logic [WIDTH-1:0]    LED,
   output logic                tick
);

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_TOGGLE = 2'b01,
      MODE_CHASE  = 2'b10,
      MODE_BLINK  = 2'b11
   } mode_t;

   localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
   localparam int TICK_W = $clog2(TICK_DIV + 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   logic [WIDTH-1:0]  sync1_reg, sync2_reg;
   logic [WIDTH-1:0]  sw_db, tgl, pattern;
   logic [WIDTH-1:0]  mode_out, pattern_load, led_next;
   logic [TICK_W-1:0] tick_cnt_reg;
   mode_t             mode_q;
   logic              blink, mode_chg, wrap;

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= sw;
         sync2_reg <= sync1_reg;
      end
   end

   // Each channel owns its debounce counter; the toggle flips on the accepted rising edge.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [DEB_W-1:0] cnt_reg;
      logic             db_reg, tgl_reg;

      always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
         if (!CPU_RESETN) begin
            cnt_reg <= '0;
            db_reg  <= 1'b0;
            tgl_reg <= 1'b0;
         end else if (sync2_reg[gi] != db_reg) begin
            if (cnt_reg == DEB_LAST) begin
               cnt_reg <= '0;
               db_reg  <= sync2_reg[gi];
               if (sync2_reg[gi])
                  tgl_reg <= ~tgl_reg;
            end else begin
               cnt_reg <= cnt_reg + DEB_W'(1);
            end
         end else begin
            cnt_reg <= '0;
         end
      end

      assign sw_db[gi] = db_reg;
      assign tgl[gi]   = tgl_reg;
   end

   assign mode_chg     = (mode != mode_q);
   assign wrap         = (tick_cnt_reg == TICK_LAST);
   assign pattern_load = (sw_db == '0) ? WIDTH'(1) : sw_db;

   // A mode change restarts the animation and wins over a coincident wrap.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         mode_q       <= MODE_DIRECT;
         tick_cnt_reg <= '0;
         tick         <= 1'b0;
         blink        <= 1'b0;
         pattern      <= '0;
      end else begin
         mode_q <= mode_t'(mode);
         if (mode_chg) begin
            tick_cnt_reg <= '0;
            tick         <= 1'b0;
            blink        <= 1'b1;
            pattern      <= pattern_load;
         end else if (wrap) begin
            tick_cnt_reg <= '0;
            tick         <= 1'b1;
            blink        <= ~blink;
            pattern      <= {pattern[WIDTH-2:0], pattern[WIDTH-1]};
         end else begin
            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
            tick         <= 1'b0;
         end
      end
   end

   always_comb begin
      mode_out = sw_db;
      case (mode_q)
         MODE_DIRECT: mode_out = sw_db;
         MODE_TOGGLE: mode_out = tgl;
         MODE_CHASE:  mode_out = pattern;
         MODE_BLINK:  mode_out = sw_db & {WIDTH{blink}};
         default:     mode_out = sw_db;
      endcase
   end

`ifdef SW_LED_PWM_EN
   logic [PWM_BITS-1:0] pwm_cnt;

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN)
         pwm_cnt <= '0;
      else
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
   end

   assign led_next = mode_out & {WIDTH{pwm_cnt < bright}};
`else
   // PWM_BITS only shapes hardware when the brightness stage is built in.
   if (PWM_BITS < 1) begin : g_pwm_bits_unused
   end

   assign led_next = mode_out;
`endif

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN)
         LED <= '0;
      else
         LED <= led_next;
   end

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Scoreboard bench for sw_led_ctrl: a cycle-level behavioural model predicts LED changes and tick
// pulses; a negedge monitor matches every observed event against the predicted value and cycle.
module tb_sw_led_ctrl;

   localparam int WIDTH = 16;
   localparam int DEB   = 4;
   localparam int TDIV  = 8;
   localparam int PWMB  = 4;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] sw    = '0;
   logic [1:0]       mode  = 2'b00;
   logic [WIDTH-1:0] led;
   logic             tick;
`ifdef SW_LED_PWM_EN
   logic [PWMB-1:0]  bright = '1;
`endif

   always #5 clk = ~clk;

   sw_led_ctrl #(
      .WIDTH(WIDTH), .DEB_CYCLES(DEB), .TICK_DIV(TDIV), .PWM_BITS(PWMB)
   ) dut (
      .CLK100MHZ (clk),
      .CPU_RESETN(rst_n),
      .sw        (sw),
      .mode      (mode),
`ifdef SW_LED_PWM_EN
      .bright    (bright),
`endif
      .LED       (led),
      .tick      (tick)
   );

   typedef struct {
      int               cyc;
      logic [WIDTH-1:0] val;
   } led_ev_t;

   led_ev_t led_q[$];
   int      tick_q[$];
   int      errors = 0;
   int      checks = 0;
   int      cyc    = 0;
   logic [WIDTH-1:0] last_led = '0;

   // Reference state: what the switches, mode and animation should be after each rising edge.
   logic [WIDTH-1:0] m_s1, m_s2, m_db, m_tgl, m_pat, m_led;
   int               m_run[WIDTH];
   bit               m_blink;
   int               m_tcnt;
   logic [1:0]       m_mq;
   int               m_pwm;

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_db = '0; m_tgl = '0; m_pat = '0; m_led = '0;
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
      m_blink = 0; m_tcnt = 0; m_mq = 2'b00; m_pwm = 0;
   endtask

   task automatic model_step();
      logic [WIDTH-1:0] shown, new_led;
      bit               new_tick;
      cyc++;
      if (!rst_n) begin
         model_reset();
         return;
      end
      case (m_mq)
         2'b00:   shown = m_db;
         2'b01:   shown = m_tgl;
         2'b10:   shown = m_pat;
         default: shown = m_blink ? m_db : '0;
      endcase
      new_led = shown;
`ifdef SW_LED_PWM_EN
      if (!(m_pwm < int'(bright))) new_led = '0;
      m_pwm = (m_pwm + 1) % (1 << PWMB);
`endif
      new_tick = 0;
      if (mode != m_mq) begin
         m_tcnt  = 0;
         m_blink = 1;
         m_pat   = (m_db == '0) ? WIDTH'(1) : m_db;
      end else if (m_tcnt == TDIV - 1) begin
         m_tcnt   = 0;
         new_tick = 1;
         m_blink  = !m_blink;
         m_pat    = {m_pat[WIDTH-2:0], m_pat[WIDTH-1]};
      end else begin
         m_tcnt++;
      end
      m_mq = mode;
      for (int i = 0; i < WIDTH; i++) begin
         if (m_s2[i] != m_db[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_db[i]  = m_s2[i];
               m_run[i] = 0;
               if (m_s2[i]) m_tgl[i] = ~m_tgl[i];
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = sw;
      if (new_led != m_led) led_q.push_back('{cyc, new_led});
      m_led = new_led;
      if (new_tick) tick_q.push_back(cyc);
   endtask

   task automatic monitor_check();
      led_ev_t ev;
      if (!rst_n) begin
         last_led = '0;
         return;
      end
      if (led !== last_led) begin
         checks++;
         if (led_q.size() == 0) begin
            errors++;
            $display("FAIL led_event cyc=%0d got=%h required=no change (stays %h)", cyc, led, last_led);
         end else begin
            ev = led_q.pop_front();
            if (ev.val !== led || ev.cyc != cyc) begin
               errors++;
               $display("FAIL led_event cyc=%0d got=%h required=%h at cyc %0d", cyc, led, ev.val, ev.cyc);
            end else begin
               $display("cyc=%0d LED=%h matches model", cyc, led);
            end
         end
         last_led = led;
      end
      if (tick === 1'b1) begin
         checks++;
         if (tick_q.size() > 0 && tick_q[0] == cyc) begin
            void'(tick_q.pop_front());
         end else begin
            errors++;
            $display("FAIL tick_event cyc=%0d got=1 required=0", cyc);
         end
      end
      while (led_q.size() > 0 && led_q[0].cyc <= cyc) begin
         ev = led_q.pop_front();
         checks++; errors++;
         $display("FAIL led_missed cyc=%0d got=%h required=%h", ev.cyc, led, ev.val);
      end
      while (tick_q.size() > 0 && tick_q[0] <= cyc) begin
         checks++; errors++;
         $display("FAIL tick_missed cyc=%0d got=0 required=1", tick_q.pop_front());
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial forever begin
      @(negedge clk);
      monitor_check();
   end

   task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, exp);
      end else begin
         $display("%s LED/tick=%h as required", name, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("reset_led", led, '0);
      check("reset_tick", WIDTH'(tick), '0);
      led_q.delete();
      tick_q.delete();
      repeat (n) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bit hit;
      int cnt_hi;
      repeat (3) @(posedge clk);
      #1;
      check("init_reset_led", led, '0);
      check("init_reset_tick", WIDTH'(tick), '0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;

      // DIRECT: debounce latency, then a short glitch that must be rejected
      step(1);
      sw = 16'hA5A5;
      step(6);
      check("direct_before_debounce", led, 16'h0000);
      step(1);
      check("direct_after_debounce", led, 16'hA5A5);
      sw[0] = ~sw[0];
      step(2);
      sw[0] = ~sw[0];
      step(10);
      check("direct_glitch_ignored", led, 16'hA5A5);

      // TOGGLE on sw[3]
      sw = '0;
      mode = 2'b01;
      do_reset(2);
      step(2);
      sw[3] = 1'b1; step(10);
      check("toggle_first_rise", led, 16'h0008);
      sw[3] = 1'b0; step(10);
      check("toggle_fall_holds", led, 16'h0008);
      sw[3] = 1'b1; step(10);
      check("toggle_second_rise", led, 16'h0000);

      // CHASE from 8001 and from an all-zero switch bank
      mode = 2'b00; sw = 16'h8001; step(12);
      mode = 2'b10; step(2);
      check("chase_entry", led, 16'h8001);
      step(8);
      check("chase_tick1", led, 16'h0003);
      step(8);
      check("chase_tick2", led, 16'h0006);
      mode = 2'b00; sw = 16'h0000; step(12);
      mode = 2'b10; step(2);
      check("chase_entry_zero", led, 16'h0001);

      // BLINK, then a mode change landing exactly on a tick wrap
      mode = 2'b00; sw = 16'hFFFF; step(12);
      mode = 2'b11; step(2);
      check("blink_entry", led, 16'hFFFF);
      step(8);
      check("blink_off", led, 16'h0000);
      step(8);
      check("blink_on", led, 16'hFFFF);
      hit = 0;
      for (int i = 0; i < 2 * TDIV && !hit; i++) begin
         step(1);
         if (m_tcnt == TDIV - 1) hit = 1;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL wrap_align got=no wrap required=wrap within %0d cycles", 2 * TDIV);
      end
      mode = 2'b00;
      step(1);
      @(negedge clk);
      check("mode_change_on_wrap_no_tick", WIDTH'(tick), '0);

      // Asynchronous reset in the middle of CHASE, timed onto a tick pulse
      mode = 2'b10; step(2);
      hit = 0;
      for (int i = 0; i < 3 * TDIV && !hit; i++) begin
         @(negedge clk);
         if (tick === 1'b1) hit = 1;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL chase_tick_wait got=no tick required=tick within %0d cycles", 3 * TDIV);
      end
      #1;
      rst_n = 1'b0;
      mode  = 2'b00;
      #1;
      check("async_reset_led", led, '0);
      check("async_reset_tick", WIDTH'(tick), '0);
      led_q.delete();
      tick_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      step(3);
      check("post_reset_still_debouncing", led, 16'h0000);
      step(10);
      check("post_reset_debounced", led, 16'hFFFF);

`ifdef SW_LED_PWM_EN
      bright = 4'd4;
      step(20);
      cnt_hi = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (led == 16'hFFFF) cnt_hi++;
      end
      check("pwm_bright4_high_count", WIDTH'(cnt_hi), WIDTH'(8));
      bright = 4'd0;
      step(2);
      cnt_hi = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (led != 16'h0000) cnt_hi++;
      end
      check("pwm_bright0_dark", WIDTH'(cnt_hi), WIDTH'(0));
      bright = '1;
      step(1);
`else
      cnt_hi = 0;
`endif

      // Randomised traffic: switch bursts, single-bit glitches, mode hops and one reset
      for (int it = 0; it < 250; it++) begin
         if (it == 125) do_reset(2);
         if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0: sw = WIDTH'($urandom);
            1: sw[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
            default: ;
         endcase
`ifdef SW_LED_PWM_EN
         if ($urandom_range(0, 7) == 0) bright = PWMB'($urandom);
`endif
         step($urandom_range(1, 12));
      end
      step(4);

      checks++;
      if (led_q.size() != 0 || tick_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d pending required=0", led_q.size() + tick_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sw_led_ctrl.md
SW_LED_CTRL -- requirements
Module: sw_led_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of switch/LED channels.
REQ-002 SHALL have parameter DEB_CYCLES, default 100000, number of stable cycles required to accept a switch change.
REQ-003 SHALL have parameter TICK_DIV, default 25000000, number of clock cycles per animation tick.
REQ-004 SHALL have parameter PWM_BITS, default 4, width of the brightness control.
REQ-005 SHALL have port CLK100MHZ, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 SHALL have port CPU_RESETN, input, 1 bit: asynchronous reset, active-low.
REQ-007 SHALL have port sw, input, WIDTH bits: raw, asynchronous switch inputs.
REQ-008 SHALL have port mode, input, 2 bits: 00 DIRECT, 01 TOGGLE, 10 CHASE, 11 BLINK.
REQ-009 SHALL have port LED, output, WIDTH bits: registered LED drive.
REQ-010 SHALL have port tick, output, 1 bit: one-cycle pulse at each animation tick.

Function
REQ-011 SHALL pass each sw bit through a 2-flop synchroniser.
REQ-012 SHALL keep a per-bit debounced value sw_db[i]; sw_db[i] takes the synchronised value after it has differed from sw_db[i] for DEB_CYCLES consecutive cycles; a return to equality clears that bit's counter.
REQ-013 SHALL run a tick counter 0..TICK_DIV-1; tick is high for one cycle when the counter wraps to 0.
REQ-014 SHALL register mode into mode_q; a cycle where mode differs from mode_q is a mode change.
REQ-015 On a mode change, SHALL clear the tick counter, suppress tick that cycle, set blink to 1, and load the chase pattern.
REQ-016 Chase pattern load: pattern takes sw_db; if sw_db is zero, pattern takes 1 (bit 0 set).
REQ-017 DIRECT: LED SHALL equal sw_db one cycle later.
REQ-018 TOGGLE: a 0->1 transition of sw_db[i] SHALL invert tgl[i]; tgl updates in every mode; LED equals tgl one cycle later.
REQ-019 CHASE: each tick SHALL rotate pattern left by one, with the MSB wrapping to bit 0; LED equals pattern one cycle later.
REQ-020 BLINK: each tick SHALL invert blink; LED equals sw_db AND-ed bitwise with blink replicated.
REQ-021 When a mode change and a tick wrap fall in the same cycle, the mode change SHALL take precedence.
REQ-022 The tick counter SHALL run in every mode.

Reset
REQ-023 While CPU_RESETN is low, all of the following SHALL be 0, asynchronously: LED, tick, synchronisers, sw_db, debounce counters, tgl, pattern, blink, tick counter, mode_q.
REQ-024 Reset deassertion during any operation SHALL resume from the reset state; no partial debounce or tick is retained.

Configuration
REQ-025 With SW_LED_PWM_EN defined, SHALL add input bright (PWM_BITS wide) and a free-running PWM_BITS counter pwm_cnt, reset to 0.
- LED = mode output AND (pwm_cnt < bright).
- bright = 0 forces LED to 0.
- bright = all-ones gives duty (2^PWM_BITS - 1)/2^PWM_BITS.
REQ-026 Without SW_LED_PWM_EN, SHALL omit the bright port and pwm_cnt; LED equals the mode output.

Verification (bench uses DEB_CYCLES=4, TICK_DIV=8, WIDTH=16)
REQ-027 DIRECT, sw 0000->A5A5: LED SHALL stay 0000 until 2+4 cycles of stable input, then show A5A5; a 2-cycle glitch on sw[0] SHALL leave LED unchanged.
REQ-028 TOGGLE, sw[3] pulsed 0->1->0->1, each level held 10 cycles: LED SHALL go 0000->0008->0000; other bits stay 0.
REQ-029 CHASE entered with sw_db=8001: LED SHALL be 8001, then 0003, then 0006 on successive ticks 8 cycles apart; entry with sw_db=0000 SHALL show 0001.
REQ-030 BLINK with sw_db=FFFF: LED SHALL alternate FFFF/0000 every 8 cycles, starting with FFFF on entry; a mode change coinciding with a tick wrap SHALL produce no tick pulse.
REQ-031 CPU_RESETN pulled low mid-CHASE: LED and tick SHALL go to 0 with no clock edge; after release, LED SHALL stay 0000 until the debounce completes.
REQ-032 With SW_LED_PWM_EN, DIRECT, sw=FFFF: bright=4 SHALL give LED high 4 of every 16 cycles; bright=0 SHALL keep LED at 0000.
